// File: rtl/loopback_err_checker_if.sv
// Receive-side loopback stream: a data word qualified by a valid strobe.
interface loopback_err_checker_if #(
    parameter int DW = 64
) ();
    logic          rx_valid;
    logic [DW-1:0] rx_data;

    modport master (output rx_valid, output rx_data);
    modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/loopback_err_checker.sv
// Incrementing-ramp checker for the loopback datapath: acquires lock, counts word errors
// while locked and re-acquires after a sustained run of mismatches.
module loopback_err_checker #(
    parameter int DW            = 64,
    parameter int CNT_W         = 32,
    parameter int LOCK_THRESH   = 16,
    parameter int UNLOCK_THRESH = 8
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    input  logic                 en,
    input  logic                 clr,
    loopback_err_checker_if.slave rx,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     word_cnt,
    output logic                 locked,
    output logic [1:0]           state
);

    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int BW = $clog2(UNLOCK_THRESH + 1);
    localparam logic [GW-1:0] LOCK_T   = GW'(LOCK_THRESH);
    localparam logic [BW-1:0] UNLOCK_T = BW'(UNLOCK_THRESH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic [DW-1:0]    exp_q,        exp_d;
    logic             prev_valid_q, prev_valid_d;
    logic [GW-1:0]    good_run_q,   good_run_d;
    logic [BW-1:0]    bad_run_q,    bad_run_d;
    logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q,   word_cnt_d;
    logic             locked_q,     locked_d;
    logic             clr_d_q,      clr_d_d;

    logic             hit;
    logic [GW-1:0]    good_nxt;
    logic [BW-1:0]    bad_nxt;

    // Counters stick at all-ones so software never sees a wrapped (small) count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign hit      = (rx.rx_data == exp_q);
    assign good_nxt = good_run_q + 1'b1;
    assign bad_nxt  = bad_run_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        prev_valid_d = prev_valid_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        err_cnt_d    = err_cnt_q;
        word_cnt_d   = word_cnt_q;
        clr_d_d      = clr;

        if (!en) begin
            state_d      = S_IDLE;
            prev_valid_d = 1'b0;
            good_run_d   = '0;
            bad_run_d    = '0;
        end else begin
            case (state_q)
                S_ACQ: begin
                    if (rx.rx_valid) begin
                        // Expected value is re-seeded from every word while hunting.
                        exp_d = rx.rx_data + 1'b1;
                        if (!prev_valid_q) begin
                            prev_valid_d = 1'b1;
                        end else if (hit) begin
                            if (good_nxt == LOCK_T) begin
                                state_d    = S_LOCK;
                                good_run_d = '0;
                            end else begin
                                good_run_d = good_nxt;
                            end
                        end else begin
                            good_run_d = '0;
                        end
                    end
                end
                S_LOCK: begin
                    if (rx.rx_valid) begin
                        // Expected free-runs: a slipped word shows up as a run of errors.
                        word_cnt_d = sat_inc(word_cnt_q);
                        exp_d      = exp_q + 1'b1;
                        if (hit) begin
                            bad_run_d = '0;
                        end else begin
                            err_cnt_d = sat_inc(err_cnt_q);
                            if (bad_nxt == UNLOCK_T) begin
                                state_d      = S_ACQ;
                                prev_valid_d = 1'b0;
                                good_run_d   = '0;
                                bad_run_d    = '0;
                            end else begin
                                bad_run_d = bad_nxt;
                            end
                        end
                    end
                end
                default: state_d = S_ACQ;
            endcase
        end

        // Clear acts on the rising edge only and overrides any count this cycle.
        if (clr && !clr_d_q) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    assign locked_d = (state_d == S_LOCK);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q      <= S_IDLE;
            exp_q        <= '0;
            prev_valid_q <= 1'b0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            err_cnt_q    <= '0;
            word_cnt_q   <= '0;
            locked_q     <= 1'b0;
            clr_d_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            prev_valid_q <= prev_valid_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            err_cnt_q    <= err_cnt_d;
            word_cnt_q   <= word_cnt_d;
            locked_q     <= locked_d;
            clr_d_q      <= clr_d_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign word_cnt = word_cnt_q;
    assign locked   = locked_q;
    assign state    = state_q;

endmodule

// File: tb/tb_loopback_err_checker.sv
// Directed bench for loopback_err_checker: a 64-bit instance, an 8-bit instance sharing the
// low data bits, and a 4-bit-counter instance, all driven by one stimulus stream.
module tb_loopback_err_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        v = 1'b0;
    logic [63:0] d = '0;

    always #5 clk = ~clk;

    loopback_err_checker_if #(.DW(64)) rx64 ();
    loopback_err_checker_if #(.DW(8))  rx8  ();

    assign rx64.rx_valid = v;
    assign rx64.rx_data  = d;
    assign rx8.rx_valid  = v;
    assign rx8.rx_data   = d[7:0];

    logic [31:0] err_a, word_a;
    logic        lock_a;
    logic [1:0]  st_a;
    logic [31:0] err_b, word_b;
    logic        lock_b;
    logic [1:0]  st_b;
    logic [3:0]  err_c, word_c;
    logic        lock_c;
    logic [1:0]  st_c;

    loopback_err_checker #(.DW(64), .CNT_W(32)) dut_a (
        .user_clk(clk), .user_rst_n(rst_n), .en(en), .clr(clr), .rx(rx64),
        .err_cnt(err_a), .word_cnt(word_a), .locked(lock_a), .state(st_a));

    loopback_err_checker #(.DW(8), .CNT_W(32)) dut_b (
        .user_clk(clk), .user_rst_n(rst_n), .en(en), .clr(clr), .rx(rx8),
        .err_cnt(err_b), .word_cnt(word_b), .locked(lock_b), .state(st_b));

    loopback_err_checker #(.DW(64), .CNT_W(4)) dut_c (
        .user_clk(clk), .user_rst_n(rst_n), .en(en), .clr(clr), .rx(rx64),
        .err_cnt(err_c), .word_cnt(word_c), .locked(lock_c), .state(st_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] data);
        v = 1'b1;
        d = data;
        tick();
        v = 1'b0;
    endtask

    task automatic do_reset();
        en    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Enable, then feed 17 ramp words: one seed plus LOCK_THRESH good compares.
    task automatic lock_on(input logic [63:0] base);
        en = 1'b1;
        tick();
        for (int k = 0; k < 17; k++) send(base + 64'(k));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_state", 64'(st_a), 64'd0);
        check_eq("rst_locked", 64'(lock_a), 64'd0);
        check_eq("rst_err", 64'(err_a), 64'd0);
        check_eq("rst_word", 64'(word_a), 64'd0);
        rst_n = 1'b1;

        // Test 1: acquire on ramp 0..19
        en = 1'b1;
        tick();
        check_eq("t1_acq", 64'(st_a), 64'd1);
        for (int i = 0; i < 20; i++) begin
            send(64'(i));
            if (i == 15) check_eq("t1_not_yet", 64'(lock_a), 64'd0);
            if (i == 16) begin
                check_eq("t1_locked", 64'(lock_a), 64'd1);
                check_eq("t1_state", 64'(st_a), 64'd2);
            end
        end
        check_eq("t1_word", 64'(word_a), 64'd3);
        check_eq("t1_err", 64'(err_a), 64'd0);

        // Test 2: single corrupt word while locked, with an idle gap earlier
        for (int i = 20; i < 100; i++) begin
            send(64'(i));
            if (i == 50) tick();
        end
        check_eq("t2_word_pre", 64'(word_a), 64'd83);
        send(64'hDEAD);
        check_eq("t2_err", 64'(err_a), 64'd1);
        check_eq("t2_locked", 64'(lock_a), 64'd1);
        tick();
        check_eq("t2_idle_word", 64'(word_a), 64'd84);
        send(64'd101);
        check_eq("t2_err_after", 64'(err_a), 64'd1);
        check_eq("t2_word", 64'(word_a), 64'd85);
        check_eq("t2_locked_after", 64'(lock_a), 64'd1);

        // Test 3: clear, then a dropped word forces re-acquire and relock
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("t3_clr_err", 64'(err_a), 64'd0);
        check_eq("t3_clr_word", 64'(word_a), 64'd0);
        for (int i = 102; i <= 110; i++) send(64'(i));
        for (int i = 112; i <= 119; i++) begin
            send(64'(i));
            if (i == 118) check_eq("t3_still_lock", 64'(st_a), 64'd2);
        end
        check_eq("t3_state_acq", 64'(st_a), 64'd1);
        check_eq("t3_err", 64'(err_a), 64'd8);
        check_eq("t3_word", 64'(word_a), 64'd17);
        for (int i = 120; i <= 136; i++) begin
            send(64'(i));
            if (i == 135) check_eq("t3_relock_early", 64'(lock_a), 64'd0);
        end
        check_eq("t3_relock", 64'(lock_a), 64'd1);
        check_eq("t3_word_acq", 64'(word_a), 64'd17);

        // Test 5: clear rising with a bad word drops that error; held clear does not re-clear
        clr = 1'b1;
        send(64'hBAD0);
        check_eq("t5_err_clr", 64'(err_a), 64'd0);
        check_eq("t5_word_clr", 64'(word_a), 64'd0);
        send(64'hBAD1);
        check_eq("t5_err_held", 64'(err_a), 64'd1);
        check_eq("t5_word_held", 64'(word_a), 64'd1);
        clr = 1'b0;
        send(64'd139);
        check_eq("t5_err_good", 64'(err_a), 64'd1);
        check_eq("t5_locked", 64'(lock_a), 64'd1);

        // Disable: back to IDLE, counters held, words ignored
        en = 1'b0;
        tick();
        check_eq("dis_state", 64'(st_a), 64'd0);
        check_eq("dis_locked", 64'(lock_a), 64'd0);
        send(64'd5);
        check_eq("dis_err", 64'(err_a), 64'd1);
        check_eq("dis_word", 64'(word_a), 64'd2);

        // Test 4: ramp wrap at DW=8 and DW=64
        do_reset();
        lock_on(64'hFFFF_FFFF_FFFF_FFEC);
        check_eq("t4_lock8", 64'(lock_b), 64'd1);
        check_eq("t4_lock64", 64'(lock_a), 64'd1);
        for (int k = 17; k < 22; k++) send(64'hFFFF_FFFF_FFFF_FFEC + 64'(k));
        check_eq("t4_err8", 64'(err_b), 64'd0);
        check_eq("t4_word8", 64'(word_b), 64'd5);
        check_eq("t4_err64", 64'(err_a), 64'd0);
        check_eq("t4_locked8", 64'(lock_b), 64'd1);

        // Test 6: saturation with 4-bit counters
        do_reset();
        lock_on(64'd0);
        check_eq("t6_lock4", 64'(lock_c), 64'd1);
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) send(~64'(17 + k));
            else            send(64'(17 + k));
        end
        check_eq("t6_err4", 64'(err_c), 64'd15);
        check_eq("t6_word4", 64'(word_c), 64'd15);
        check_eq("t6_locked4", 64'(lock_c), 64'd1);
        check_eq("t6_err32", 64'(err_a), 64'd20);
        check_eq("t6_word32", 64'(word_a), 64'd40);

        // Test 7: asynchronous reset while locked
        do_reset();
        lock_on(64'd0);
        for (int k = 0; k < 5; k++) send(64'hF000 + 64'(k));
        send(64'd22);
        check_eq("t7_err_pre", 64'(err_a), 64'd5);
        check_eq("t7_lock_pre", 64'(lock_a), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t7_err_rst", 64'(err_a), 64'd0);
        check_eq("t7_lock_rst", 64'(lock_a), 64'd0);
        check_eq("t7_state_rst", 64'(st_a), 64'd0);
        check_eq("t7_word_rst", 64'(word_a), 64'd0);
        tick();
        rst_n = 1'b1;
        check_eq("t7_idle", 64'(st_a), 64'd0);
        tick();
        check_eq("t7_resume_acq", 64'(st_a), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
